// File: rtl/spi_slave_regs.sv
// SPI responder emulating the control-port register file of the SBIS BOS device.
// The SPI lines are oversampled on the system clock. 16-bit frames are decoded as
// {rw, addr[6:0]} followed by a data byte. Reads return data MSB first on miso.
module spi_slave_regs #(
   parameter int         N_REGS  = 16,
   parameter bit         CPOL    = 1'b0,
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                n_cs,
   input  logic                sclk,
   input  logic                mosi,
   output logic                miso,
   output logic [8*N_REGS-1:0] regs,
   output logic                wr_pulse,
   output logic [6:0]          wr_addr,
   output logic [7:0]          wr_data,
   output logic                addr_err,
   output logic                frame_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   localparam logic [7:0] N_REGS_W = 8'(N_REGS);

   state_t     state;
   state_t     state_next;

   logic [1:0] cs_sync;
   logic [1:0] sclk_sync;
   logic [1:0] mosi_sync;
   logic       sclk_prev;
   logic       cs_s;
   logic       sclk_s;
   logic       mosi_s;
   logic       sample_edge;
   logic       shift_edge;

   logic [2:0] bit_cnt;
   logic [7:0] shift_in;
   logic [7:0] rx_byte;
   logic       rw;
   logic [6:0] addr;
   logic       addr_ok;
   logic [7:0] tx;
   logic [7:0] rd_data;
   logic       miso_q;
   logic       last_bit;

   logic       hdr_load;
   logic       frame_end;
   logic       abort;
   logic       shift_en;
   logic       do_write;
   logic       do_aerr;

   logic [7:0] reg_file [N_REGS];

   assign cs_s     = cs_sync[1];
   assign sclk_s   = sclk_sync[1];
   assign mosi_s   = mosi_sync[1];
   assign rx_byte  = {shift_in[6:0], mosi_s};
   assign last_bit = sample_edge && (bit_cnt == 3'd7);
   assign addr_ok  = ({1'b0, addr} < N_REGS_W);
   assign miso     = miso_q;

   // Sample and shift edges are found on the polarity-normalised synchronized clock,
   // so the sample edge is always the first edge leaving the idle level.
   assign sample_edge = (sclk_s ^ CPOL) & ~(sclk_prev ^ CPOL);
   assign shift_edge  = ~(sclk_s ^ CPOL) & (sclk_prev ^ CPOL);

   // Two-flop synchronizers for the asynchronous SPI pins, plus the sclk history
   // flop used for edge detection. The chip-select synchronizer resets to "selected"
   // so that a frame still running across a reset is parked in DONE until n_cs truly rises.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cs_sync   <= 2'b00;
         sclk_sync <= {2{CPOL}};
         mosi_sync <= 2'b00;
         sclk_prev <= CPOL;
      end else begin
         cs_sync   <= {cs_sync[0], n_cs};
         sclk_sync <= {sclk_sync[0], sclk};
         mosi_sync <= {mosi_sync[0], mosi};
         sclk_prev <= sclk_s;
      end
   end

   // State register; reset parks the machine in DONE so a half-seen frame is never decoded.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= DONE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a 16th sample edge wins over a simultaneous chip-select rise.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (!cs_s) state_next = ADDR;
         ADDR: begin
            if (cs_s) begin
               state_next = IDLE;
            end else if (last_bit) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (last_bit) begin
               state_next = DONE;
            end else if (cs_s) begin
               state_next = IDLE;
            end
         end
         DONE: if (cs_s) state_next = IDLE;
         default: state_next = DONE;
      endcase
   end

   // Per-state control decode: header latch, frame completion, abort and read shifting.
   always_comb begin
      hdr_load  = 1'b0;
      frame_end = 1'b0;
      abort     = 1'b0;
      shift_en  = 1'b0;
      case (state)
         ADDR: begin
            abort    = cs_s;
            hdr_load = !cs_s && last_bit;
         end
         DATA: begin
            frame_end = last_bit;
            abort     = cs_s && !last_bit;
            shift_en  = rw && shift_edge;
         end
         default: ;
      endcase
   end

   assign do_write = frame_end && !rw && addr_ok;
   assign do_aerr  = frame_end && !addr_ok;

   // Read lookup for the address arriving with the 8th sample edge; out-of-range reads give zero.
   always_comb begin
      rd_data = 8'h00;
      for (int i = 0; i < N_REGS; i++) begin
         if (rx_byte[6:0] == 7'(i)) rd_data = reg_file[i];
      end
   end

   // Serial datapath: bit counter, input shifter, header latch and the read-data shifter.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bit_cnt  <= 3'd0;
         shift_in <= 8'h00;
         rw       <= 1'b0;
         addr     <= 7'd0;
         tx       <= 8'h00;
         miso_q   <= 1'b0;
      end else begin
         if (state == IDLE) begin
            bit_cnt <= 3'd0;
         end else if (sample_edge && (state == ADDR || state == DATA)) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= rx_byte;
         end
         if (hdr_load) begin
            rw   <= rx_byte[7];
            addr <= rx_byte[6:0];
            tx   <= rd_data;
         end
         if (state_next != DATA) begin
            miso_q <= 1'b0;
         end else if (shift_en) begin
            miso_q <= tx[7];
            tx     <= {tx[6:0], 1'b0};
         end
      end
   end

   // Register file and strobes, all registered one clock after the deciding sample edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < N_REGS; i++) reg_file[i] <= RST_VAL;
         wr_pulse  <= 1'b0;
         wr_addr   <= 7'd0;
         wr_data   <= 8'h00;
         addr_err  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         wr_pulse  <= do_write;
         addr_err  <= do_aerr;
         frame_err <= abort;
         if (do_write) begin
            wr_addr <= addr;
            wr_data <= rx_byte;
            for (int i = 0; i < N_REGS; i++) begin
               if (addr == 7'(i)) reg_file[i] <= rx_byte;
            end
         end
      end
   end

   for (genvar g = 0; g < N_REGS; g++) begin : g_flat
      assign regs[8*g +: 8] = reg_file[g];
   end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: a CPOL=0 and a CPOL=1 instance are driven
// with directed and random SPI frames and compared against a frame-level register model.
module tb_spi_slave_regs;

   localparam int NR   = 16;
   localparam int HALF = 40;

   logic clk = 1'b0;
   logic n_rst;
   logic mosi;
   logic n_cs0, sclk0, n_cs1, sclk1;

   logic          miso0, miso1;
   logic [127:0]  regs0, regs1;
   logic          wr_pulse0, wr_pulse1;
   logic [6:0]    wr_addr0, wr_addr1;
   logic [7:0]    wr_data0, wr_data1;
   logic          addr_err0, addr_err1;
   logic          frame_err0, frame_err1;

   int asserts = 0;
   int fails   = 0;

   int wr_cnt [2];
   int ae_cnt [2];
   int fe_cnt [2];
   int width_err = 0;
   logic [5:0] strobes_prev = '0;

   logic [7:0] model [2][NR];
   logic [6:0] last_wa [2];
   logic [7:0] last_wd [2];

   spi_slave_regs #(.N_REGS(NR), .CPOL(1'b0), .RST_VAL(8'h00)) dut0 (
      .clk(clk), .n_rst(n_rst), .n_cs(n_cs0), .sclk(sclk0), .mosi(mosi),
      .miso(miso0), .regs(regs0), .wr_pulse(wr_pulse0), .wr_addr(wr_addr0),
      .wr_data(wr_data0), .addr_err(addr_err0), .frame_err(frame_err0)
   );

   spi_slave_regs #(.N_REGS(NR), .CPOL(1'b1), .RST_VAL(8'h00)) dut1 (
      .clk(clk), .n_rst(n_rst), .n_cs(n_cs1), .sclk(sclk1), .mosi(mosi),
      .miso(miso1), .regs(regs1), .wr_pulse(wr_pulse1), .wr_addr(wr_addr1),
      .wr_data(wr_data1), .addr_err(addr_err1), .frame_err(frame_err1)
   );

   always #5 clk = ~clk;

   // Strobe counters sampled on the falling edge; any strobe high two cycles running is a width error.
   always @(negedge clk) begin
      if (wr_pulse0)  wr_cnt[0] <= wr_cnt[0] + 1;
      if (wr_pulse1)  wr_cnt[1] <= wr_cnt[1] + 1;
      if (addr_err0)  ae_cnt[0] <= ae_cnt[0] + 1;
      if (addr_err1)  ae_cnt[1] <= ae_cnt[1] + 1;
      if (frame_err0) fe_cnt[0] <= fe_cnt[0] + 1;
      if (frame_err1) fe_cnt[1] <= fe_cnt[1] + 1;
      if (({wr_pulse0, addr_err0, frame_err0, wr_pulse1, addr_err1, frame_err1} & strobes_prev) != 6'd0)
         width_err <= width_err + 1;
      strobes_prev <= {wr_pulse0, addr_err0, frame_err0, wr_pulse1, addr_err1, frame_err1};
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      asserts++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic setCs(input int inst, input logic v);
      if (inst == 0) n_cs0 = v; else n_cs1 = v;
   endtask

   // Drives the clock of the chosen instance to its active (sample) or idle level.
   task automatic setSclk(input int inst, input logic active);
      if (inst == 0) sclk0 = active; else sclk1 = ~active;
   endtask

   // Clocks nbits of word out MSB first (CPHA=0), capturing miso just before each sample edge.
   // A nonzero reset_at pulses n_rst right after that bit's shift edge, with n_cs held low.
   task automatic applyStimulus(input int inst, input logic [31:0] word, input int nbits,
                                input int reset_at, output logic [31:0] rx);
      rx = '0;
      mosi = word[nbits-1];
      setCs(inst, 1'b0);
      #(HALF);
      for (int k = 1; k <= nbits; k++) begin
         rx[nbits-k] = (inst == 0) ? miso0 : miso1;
         setSclk(inst, 1'b1);
         #(HALF);
         setSclk(inst, 1'b0);
         if (k < nbits) mosi = word[nbits-k-1];
         if (k == reset_at) begin
            n_rst = 1'b0;
            #20;
            n_rst = 1'b1;
            #(HALF-20);
         end else begin
            #(HALF);
         end
      end
      setCs(inst, 1'b1);
      #(4*HALF);
   endtask

   function automatic logic [127:0] expRegs(input int inst);
      logic [127:0] r;
      for (int i = 0; i < NR; i++) r[8*i +: 8] = model[inst][i];
      return r;
   endfunction

   // Runs one frame and checks every observable against the frame-level model.
   task automatic doFrame(input int inst, input logic [31:0] word, input int nbits, input int reset_at);
      int wr_b, ae_b, fe_b;
      int exp_wr, exp_ae, exp_fe;
      logic [31:0] rx, exp_rx;
      logic [7:0] hdr, dat, rdata;
      int a;
      wr_b = wr_cnt[inst];
      ae_b = ae_cnt[inst];
      fe_b = fe_cnt[inst];
      applyStimulus(inst, word, nbits, reset_at, rx);
      exp_wr = 0; exp_ae = 0; exp_fe = 0; exp_rx = '0; rdata = 8'h00;
      hdr = 8'(word >> (nbits-8));
      dat = (nbits >= 16) ? 8'(word >> (nbits-16)) : 8'h00;
      a = int'(hdr[6:0]);
      if (reset_at > 0) begin
         for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NR; i++) model[j][i] = 8'h00;
            last_wa[j] = 7'd0;
            last_wd[j] = 8'h00;
         end
      end else if (nbits < 16) begin
         exp_fe = 1;
      end else begin
         if (a >= NR) begin
            exp_ae = 1;
         end else if (hdr[7]) begin
            rdata = model[inst][a];
         end else begin
            model[inst][a] = dat;
            exp_wr = 1;
            last_wa[inst] = hdr[6:0];
            last_wd[inst] = dat;
         end
         if (hdr[7]) exp_rx = 32'(rdata) << (nbits-16);
      end
      checkOutput($sformatf("miso_%0h", word), rx, exp_rx);
      checkOutput($sformatf("wr_pulse_%0h", word), wr_cnt[inst] - wr_b, exp_wr);
      checkOutput($sformatf("addr_err_%0h", word), ae_cnt[inst] - ae_b, exp_ae);
      checkOutput($sformatf("frame_err_%0h", word), fe_cnt[inst] - fe_b, exp_fe);
      checkOutput($sformatf("wr_addr_%0h", word), (inst == 0) ? wr_addr0 : wr_addr1, last_wa[inst]);
      checkOutput($sformatf("wr_data_%0h", word), (inst == 0) ? wr_data0 : wr_data1, last_wd[inst]);
      checkOutput($sformatf("regs_%0h", word), (inst == 0) ? regs0 : regs1, expRegs(inst));
   endtask

   // Directed test-plan frames followed by random traffic on both instances.
   initial begin
      logic [31:0] w;
      logic [7:0]  h, d, e;
      int          inst, nb;
      n_rst = 1'b0;
      n_cs0 = 1'b1; n_cs1 = 1'b1;
      sclk0 = 1'b0; sclk1 = 1'b1;
      mosi  = 1'b0;
      for (int j = 0; j < 2; j++) begin
         wr_cnt[j] = 0; ae_cnt[j] = 0; fe_cnt[j] = 0;
         last_wa[j] = 7'd0; last_wd[j] = 8'h00;
         for (int i = 0; i < NR; i++) model[j][i] = 8'h00;
      end
      #23;
      n_rst = 1'b1;
      repeat (10) @(posedge clk);
      #3;

      checkOutput("reset_regs0", regs0, 128'h0);
      checkOutput("reset_regs1", regs1, 128'h0);
      checkOutput("reset_miso", {miso0, miso1}, 2'b00);
      checkOutput("reset_wr_addr", {wr_addr0, wr_addr1}, 14'h0);
      checkOutput("reset_wr_data", {wr_data0, wr_data1}, 16'h0);
      checkOutput("reset_strobes", {wr_pulse0, addr_err0, frame_err0, wr_pulse1, addr_err1, frame_err1}, 6'h0);

      doFrame(0, 32'h0000_03A5, 16, 0);
      doFrame(0, 32'h0000_8300, 16, 0);
      doFrame(0, 32'h0000_7F11, 16, 0);
      doFrame(0, 32'h0000_FF00, 16, 0);
      doFrame(0, 32'h0000_0255 >> 5, 11, 0);
      doFrame(0, 32'h0000_0255, 16, 0);
      doFrame(1, 32'h0001_42FF, 24, 0);
      doFrame(0, 32'h0000_0C3C, 16, 5);
      doFrame(0, 32'h0000_0C3C, 16, 0);
      doFrame(0, 32'h0000_8C00, 16, 0);

      for (int n = 0; n < 24; n++) begin
         inst = int'($urandom_range(0, 1));
         h = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
         d = 8'($urandom);
         e = 8'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? 24 : 16;
         w = (nb == 24) ? {8'h00, h, d, e} : {16'h0000, h, d};
         doFrame(inst, w, nb, 0);
      end

      checkOutput("strobe_width", width_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
